// File: rtl/ant_pkg.sv
// Shared Langton's-ant encodings: direction codes, sequencer states and turn helpers.
// Used by the stepper and the ant_body renderer so both agree on the direction encoding.
package ant_pkg;

   localparam logic [1:0] DIR_UP    = 2'd0;
   localparam logic [1:0] DIR_DOWN  = 2'd1;
   localparam logic [1:0] DIR_LEFT  = 2'd2;
   localparam logic [1:0] DIR_RIGHT = 2'd3;

   typedef enum logic [2:0] {
      S_CLEAR = 3'd0,
      S_IDLE  = 3'd1,
      S_READ  = 3'd2,
      S_WRITE = 3'd3,
      S_MOVE  = 3'd4
   } state_t;

   function automatic logic [1:0] turn_right(input logic [1:0] d);
      case (d)
         DIR_UP:    return DIR_RIGHT;
         DIR_RIGHT: return DIR_DOWN;
         DIR_DOWN:  return DIR_LEFT;
         default:   return DIR_UP;
      endcase
   endfunction

   function automatic logic [1:0] turn_left(input logic [1:0] d);
      case (d)
         DIR_UP:    return DIR_LEFT;
         DIR_LEFT:  return DIR_DOWN;
         DIR_DOWN:  return DIR_RIGHT;
         default:   return DIR_UP;
      endcase
   endfunction

endpackage

// File: rtl/ant_grid_ram.sv
// N x 1 cell-colour store: one sync write port, one async read port for the sequencer,
// one registered display read port (1-cycle latency, no write forwarding, never stalls).
module ant_grid_ram #(
   parameter int N  = 25,
   parameter int AW = 7
)(
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic          wdat_i,
   input  logic [AW-1:0] raddr_i,
   output logic          rdat_o,
   input  logic [AW-1:0] daddr_i,
   output logic          ddat_o
);

   logic [N-1:0] grid_q;
   logic [N-1:0] rd_shift;
   logic [N-1:0] disp_shift;
   logic         ddat_q;

   always_ff @(posedge clk_i) begin
      for (int i = 0; i < N; i++) begin
         if (we_i && (waddr_i == AW'(i))) grid_q[i] <= wdat_i;
      end
   end

   // Shifting rather than indexing makes out-of-range display addresses read as 0.
   assign rd_shift   = grid_q >> raddr_i;
   assign disp_shift = grid_q >> daddr_i;
   assign rdat_o     = rd_shift[0];

   always_ff @(posedge clk_i) begin
      if (rst_i) ddat_q <= 1'b0;
      else       ddat_q <= disp_shift[0];
   end

   assign ddat_o = ddat_q;

endmodule

// File: rtl/ant_stepper.sv
// Langton's ant sequencer: owns ant position/direction, steps READ->WRITE->MOVE (3 cycles), clears grid in N cycles.
// istep/iclear are dropped while busy, except iclear during a step which is held until the step ends.
module ant_stepper
   import ant_pkg::*;
#(
   parameter  int C_NUM_OF_CELLS_X = 5,
   parameter  int C_NUM_OF_CELLS_Y = 5,
   parameter  int C_STEP_PERIOD    = 4,
   localparam int XW = $clog2(C_NUM_OF_CELLS_X),
   localparam int YW = $clog2(C_NUM_OF_CELLS_Y)
)(
   input  logic          iclk,
   input  logic          irst,
   input  logic          istep,
   input  logic          irun,
   input  logic          iclear,
   input  logic [XW-1:0] column,
   input  logic [YW-1:0] line,
   output logic          ocell,
   output logic [XW-1:0] cur_pos_x,
   output logic [YW-1:0] cur_pos_y,
   output logic [1:0]    direction,
   output logic          obusy,
   output logic          odone,
   output logic [31:0]   ostep_cnt
);

   localparam int N  = C_NUM_OF_CELLS_X * C_NUM_OF_CELLS_Y;
   localparam int AW = XW + YW + 1;
   localparam int PW = $clog2(C_STEP_PERIOD);

   localparam logic [XW-1:0] X_MAX  = XW'(C_NUM_OF_CELLS_X - 1);
   localparam logic [YW-1:0] Y_MAX  = YW'(C_NUM_OF_CELLS_Y - 1);
   localparam logic [XW-1:0] X_MID  = XW'(C_NUM_OF_CELLS_X / 2);
   localparam logic [YW-1:0] Y_MID  = YW'(C_NUM_OF_CELLS_Y / 2);
   localparam logic [AW-1:0] N_LAST = AW'(N - 1);
   localparam logic [PW-1:0] P_LAST = PW'(C_STEP_PERIOD - 1);

   state_t        state_q, state_d;
   logic [AW-1:0] idx_q;
   logic [XW-1:0] pos_x_q;
   logic [YW-1:0] pos_y_q;
   logic [1:0]    dir_q, new_dir_q;
   logic          c_q, done_q, clr_pend_q;
   logic [31:0]   cnt_q;
   logic [PW-1:0] per_q;

   logic          trigger;
   logic          ram_we, ram_wdat, ram_rdat;
   logic [AW-1:0] ram_waddr, ant_addr, disp_addr;

   assign trigger   = istep | (irun & (per_q == P_LAST));
   assign ant_addr  = AW'(pos_y_q) * AW'(C_NUM_OF_CELLS_X) + AW'(pos_x_q);
   assign disp_addr = AW'(line) * AW'(C_NUM_OF_CELLS_X) + AW'(column);

   always_ff @(posedge iclk) begin
      if (irst) state_q <= S_CLEAR;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_CLEAR: if (idx_q == N_LAST) state_d = S_IDLE;
         S_IDLE: begin
            if (iclear || clr_pend_q) state_d = S_CLEAR;
            else if (trigger)         state_d = S_READ;
         end
         S_READ:  state_d = S_WRITE;
         S_WRITE: state_d = S_MOVE;
         S_MOVE:  state_d = S_IDLE;
         default: state_d = S_CLEAR;
      endcase
   end

   // Write enable is gated by irst so an interrupted operation never commits a cell.
   always_comb begin
      obusy     = (state_q != S_IDLE);
      ram_we    = !irst && ((state_q == S_CLEAR) || (state_q == S_WRITE));
      ram_waddr = (state_q == S_CLEAR) ? idx_q : ant_addr;
      ram_wdat  = (state_q == S_CLEAR) ? 1'b0 : ~c_q;
   end

   always_ff @(posedge iclk) begin
      if (irst) begin
         idx_q      <= '0;
         pos_x_q    <= X_MID;
         pos_y_q    <= Y_MID;
         dir_q      <= DIR_UP;
         new_dir_q  <= DIR_UP;
         c_q        <= 1'b0;
         done_q     <= 1'b0;
         clr_pend_q <= 1'b0;
         cnt_q      <= '0;
         per_q      <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_CLEAR: begin
               pos_x_q    <= X_MID;
               pos_y_q    <= Y_MID;
               dir_q      <= DIR_UP;
               cnt_q      <= '0;
               clr_pend_q <= 1'b0;
               if (idx_q == N_LAST) begin
                  idx_q  <= '0;
                  done_q <= 1'b1;
               end else begin
                  idx_q <= idx_q + AW'(1);
               end
            end
            S_IDLE:  clr_pend_q <= 1'b0;
            S_READ:  c_q <= ram_rdat;
            S_WRITE: new_dir_q <= c_q ? turn_left(dir_q) : turn_right(dir_q);
            S_MOVE: begin
               dir_q  <= new_dir_q;
               done_q <= 1'b1;
               cnt_q  <= cnt_q + 32'd1;
               case (new_dir_q)
                  DIR_UP:    pos_y_q <= (pos_y_q == '0)    ? Y_MAX : pos_y_q - YW'(1);
                  DIR_DOWN:  pos_y_q <= (pos_y_q == Y_MAX) ? '0    : pos_y_q + YW'(1);
                  DIR_LEFT:  pos_x_q <= (pos_x_q == '0)    ? X_MAX : pos_x_q - XW'(1);
                  default:   pos_x_q <= (pos_x_q == X_MAX) ? '0    : pos_x_q + XW'(1);
               endcase
            end
            default: ;
         endcase
         if (iclear && (state_q == S_READ || state_q == S_WRITE || state_q == S_MOVE))
            clr_pend_q <= 1'b1;
         if (!irun)                  per_q <= '0;
         else if (state_q == S_IDLE) per_q <= trigger ? '0 : per_q + PW'(1);
      end
   end

   ant_grid_ram #(.N(N), .AW(AW)) u_grid (
      .clk_i   (iclk),
      .rst_i   (irst),
      .we_i    (ram_we),
      .waddr_i (ram_waddr),
      .wdat_i  (ram_wdat),
      .raddr_i (ant_addr),
      .rdat_o  (ram_rdat),
      .daddr_i (disp_addr),
      .ddat_o  (ocell)
   );

   assign cur_pos_x = pos_x_q;
   assign cur_pos_y = pos_y_q;
   assign direction = dir_q;
   assign odone     = done_q;
   assign ostep_cnt = cnt_q;

endmodule

// File: tb/tb_ant_stepper.sv
// Directed bench for ant_stepper on a 5x5 grid with a behavioural Langton's-ant model.
module tb_ant_stepper;

   localparam int X = 5;
   localparam int Y = 5;
   localparam int N = X * Y;

   logic        iclk = 1'b0;
   logic        irst, istep, irun, iclear;
   logic [2:0]  column, line;
   logic        ocell;
   logic [2:0]  cur_pos_x, cur_pos_y;
   logic [1:0]  direction;
   logic        obusy, odone;
   logic [31:0] ostep_cnt;

   int checks = 0;
   int errors = 0;

   bit mgrid[N];
   int mx, my, mdir, mcnt;

   ant_stepper #(.C_NUM_OF_CELLS_X(5), .C_NUM_OF_CELLS_Y(5), .C_STEP_PERIOD(4)) dut (
      .iclk(iclk), .irst(irst), .istep(istep), .irun(irun), .iclear(iclear),
      .column(column), .line(line), .ocell(ocell),
      .cur_pos_x(cur_pos_x), .cur_pos_y(cur_pos_y), .direction(direction),
      .obusy(obusy), .odone(odone), .ostep_cnt(ostep_cnt)
   );

   always #5 iclk = ~iclk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge iclk);
      @(negedge iclk);
   endtask

   task automatic wait_done(input int limit, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (odone !== 1'b1 && n < limit);
   endtask

   task automatic read_cell(input int x, input int y, output logic v);
      column = 3'(x);
      line   = 3'(y);
      tick();
      v = ocell;
   endtask

   task automatic model_clear;
      foreach (mgrid[i]) mgrid[i] = 1'b0;
      mx = 2; my = 2; mdir = 0; mcnt = 0;
   endtask

   // Direction codes: 0 up, 1 down, 2 left, 3 right.
   task automatic model_step;
      int a;
      a = my * X + mx;
      if (mgrid[a] == 1'b0) begin
         case (mdir) 0: mdir = 3; 3: mdir = 1; 1: mdir = 2; default: mdir = 0; endcase
      end else begin
         case (mdir) 0: mdir = 2; 2: mdir = 1; 1: mdir = 3; default: mdir = 0; endcase
      end
      mgrid[a] = ~mgrid[a];
      case (mdir)
         0: my = (my == 0) ? Y - 1 : my - 1;
         1: my = (my == Y - 1) ? 0 : my + 1;
         2: mx = (mx == 0) ? X - 1 : mx - 1;
         default: mx = (mx == X - 1) ? 0 : mx + 1;
      endcase
      mcnt++;
   endtask

   task automatic test_reset;
      int  n;
      bit  busy_ok;
      logic v;
      irst = 1'b1; istep = 1'b0; irun = 1'b0; iclear = 1'b0; column = '0; line = '0;
      tick(); tick();
      checks++; if (obusy !== 1'b1) begin errors++; $display("FAIL reset_busy got %b want 1", obusy); end
      checks++; if (odone !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", odone); end
      checks++; if (cur_pos_x !== 3'd2 || cur_pos_y !== 3'd2) begin errors++; $display("FAIL reset_pos got (%0d,%0d) want (2,2)", cur_pos_x, cur_pos_y); end
      checks++; if (direction !== 2'd0) begin errors++; $display("FAIL reset_dir got %0d want 0", direction); end
      checks++; if (ostep_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", ostep_cnt); end
      checks++; if (ocell !== 1'b0) begin errors++; $display("FAIL reset_ocell got %b want 0", ocell); end
      irst = 1'b0;
      busy_ok = 1'b1;
      n = 0;
      do begin
         tick();
         n++;
         if (odone !== 1'b1 && obusy !== 1'b1) busy_ok = 1'b0;
      end while (odone !== 1'b1 && n < 100);
      checks++; if (n != 25) begin errors++; $display("FAIL clear_len got %0d want 25", n); end
      checks++; if (!busy_ok) begin errors++; $display("FAIL clear_busy got 0 during clear want 1"); end
      checks++; if (obusy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", obusy); end
      model_clear();
      for (int y = 0; y < Y; y++)
         for (int x = 0; x < X; x++) begin
            read_cell(x, y, v);
            checks++; if (v !== 1'b0) begin errors++; $display("FAIL reset_grid (%0d,%0d) got %b want 0", x, y, v); end
         end
   endtask

   task automatic test_single_step;
      logic v;
      istep = 1'b1;
      tick();
      istep = 1'b0;
      checks++; if (obusy !== 1'b1 || odone !== 1'b0) begin errors++; $display("FAIL step_t1 busy/done got %b/%b want 1/0", obusy, odone); end
      tick(); tick();
      checks++; if (odone !== 1'b0 || cur_pos_x !== 3'd2 || direction !== 2'd0) begin
         errors++; $display("FAIL step_t2 done/x/dir got %b/%0d/%0d want 0/2/0", odone, cur_pos_x, direction); end
      tick();
      checks++; if (odone !== 1'b1) begin errors++; $display("FAIL step_t3_done got %b want 1", odone); end
      checks++; if (cur_pos_x !== 3'd3 || cur_pos_y !== 3'd2) begin errors++; $display("FAIL step1_pos got (%0d,%0d) want (3,2)", cur_pos_x, cur_pos_y); end
      checks++; if (direction !== 2'd3) begin errors++; $display("FAIL step1_dir got %0d want 3", direction); end
      checks++; if (ostep_cnt !== 32'd1) begin errors++; $display("FAIL step1_cnt got %0d want 1", ostep_cnt); end
      tick();
      checks++; if (odone !== 1'b0 || obusy !== 1'b0) begin errors++; $display("FAIL step1_pulse done/busy got %b/%b want 0/0", odone, obusy); end
      model_step();
      read_cell(2, 2, v);
      checks++; if (v !== 1'b1) begin errors++; $display("FAIL step1_cell got %b want 1", v); end
   endtask

   task automatic test_steps;
      int   ex[4] = '{3, 2, 2, 1};
      int   ey[4] = '{3, 3, 2, 2};
      int   ed[4] = '{1, 2, 0, 2};
      int   n;
      logic v;
      for (int k = 0; k < 4; k++) begin
         istep = 1'b1; tick(); istep = 1'b0;
         wait_done(20, n);
         model_step();
         checks++; if (n != 3) begin errors++; $display("FAIL dir_step%0d_lat got %0d want 3", k + 2, n); end
         checks++; if (cur_pos_x !== 3'(ex[k]) || cur_pos_y !== 3'(ey[k]) || direction !== 2'(ed[k])) begin
            errors++; $display("FAIL dir_step%0d got (%0d,%0d,d%0d) want (%0d,%0d,d%0d)",
                               k + 2, cur_pos_x, cur_pos_y, direction, ex[k], ey[k], ed[k]); end
      end
      read_cell(2, 2, v);
      checks++; if (v !== 1'b0) begin errors++; $display("FAIL step5_cell22 got %b want 0", v); end
      while (mcnt < 200) begin
         istep = 1'b1; tick(); istep = 1'b0;
         wait_done(20, n);
         model_step();
         checks++; if (n != 3 || cur_pos_x !== 3'(mx) || cur_pos_y !== 3'(my) || direction !== 2'(mdir) || ostep_cnt !== 32'(mcnt)) begin
            errors++; $display("FAIL long_step%0d got lat%0d (%0d,%0d,d%0d) cnt%0d want lat3 (%0d,%0d,d%0d) cnt%0d",
                               mcnt, n, cur_pos_x, cur_pos_y, direction, ostep_cnt, mx, my, mdir, mcnt); end
      end
      for (int y = 0; y < Y; y++)
         for (int x = 0; x < X; x++) begin
            read_cell(x, y, v);
            checks++; if (v !== mgrid[y * X + x]) begin errors++; $display("FAIL grid200 (%0d,%0d) got %b want %b", x, y, v, mgrid[y * X + x]); end
         end
   endtask

   task automatic test_run;
      int n;
      irun = 1'b1;
      for (int k = 0; k < 2; k++) begin
         n = 0;
         do begin
            tick();
            n++;
            if (k == 0 && n == 4) istep = 1'b1;
            if (n == 6) istep = 1'b0;
         end while (odone !== 1'b1 && n < 50);
         model_step();
         checks++; if (n != 7) begin errors++; $display("FAIL run%0d_interval got %0d want 7", k, n); end
         checks++; if (ostep_cnt !== 32'(mcnt) || cur_pos_x !== 3'(mx) || cur_pos_y !== 3'(my)) begin
            errors++; $display("FAIL run%0d_state got cnt%0d (%0d,%0d) want cnt%0d (%0d,%0d)",
                               k, ostep_cnt, cur_pos_x, cur_pos_y, mcnt, mx, my); end
      end
      irun = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      checks++; if (ostep_cnt !== 32'(mcnt) || obusy !== 1'b0) begin
         errors++; $display("FAIL run_off got cnt%0d busy%b want cnt%0d busy0", ostep_cnt, obusy, mcnt); end
      irun = 1'b1; tick(); tick();
      irun = 1'b0; tick();
      irun = 1'b1;
      wait_done(50, n);
      model_step();
      irun = 1'b0;
      checks++; if (n != 7) begin errors++; $display("FAIL period_restart got %0d want 7", n); end
      checks++; if (ostep_cnt !== 32'(mcnt)) begin errors++; $display("FAIL period_cnt got %0d want %0d", ostep_cnt, mcnt); end
      tick();
   endtask

   task automatic test_clear;
      int   n;
      logic v;
      istep = 1'b1; tick(); istep = 1'b0;
      tick();
      iclear = 1'b1; tick(); iclear = 1'b0;
      tick();
      model_step();
      checks++; if (odone !== 1'b1 || cur_pos_x !== 3'(mx) || cur_pos_y !== 3'(my) || direction !== 2'(mdir)) begin
         errors++; $display("FAIL clr_step got done%b (%0d,%0d,d%0d) want done1 (%0d,%0d,d%0d)",
                            odone, cur_pos_x, cur_pos_y, direction, mx, my, mdir); end
      tick();
      checks++; if (obusy !== 1'b1) begin errors++; $display("FAIL clr_pending got busy %b want 1", obusy); end
      wait_done(100, n);
      checks++; if (n != 25) begin errors++; $display("FAIL clr_len got %0d want 25", n); end
      checks++; if (cur_pos_x !== 3'd2 || cur_pos_y !== 3'd2 || direction !== 2'd0 || ostep_cnt !== 32'd0) begin
         errors++; $display("FAIL clr_state got (%0d,%0d,d%0d) cnt%0d want (2,2,d0) cnt0", cur_pos_x, cur_pos_y, direction, ostep_cnt); end
      model_clear();
      for (int k = 0; k < 3; k++) begin
         istep = 1'b1; tick(); istep = 1'b0;
         wait_done(20, n);
         model_step();
      end
      iclear = 1'b1; tick(); iclear = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      irst = 1'b1; tick(); irst = 1'b0;
      checks++; if (obusy !== 1'b1 || odone !== 1'b0) begin errors++; $display("FAIL midclr_rst busy/done got %b/%b want 1/0", obusy, odone); end
      wait_done(100, n);
      checks++; if (n != 25) begin errors++; $display("FAIL midclr_len got %0d want 25", n); end
      model_clear();
      for (int y = 0; y < Y; y++)
         for (int x = 0; x < X; x++) begin
            read_cell(x, y, v);
            checks++; if (v !== 1'b0) begin errors++; $display("FAIL midclr_grid (%0d,%0d) got %b want 0", x, y, v); end
         end
   endtask

   initial begin
      test_reset();
      test_single_step();
      test_steps();
      test_run();
      test_clear();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
